whack_round_ctrl: RTL and testbench

WHACK_ROUND_CTRL -- requirements
Module: whack_round_ctrl

---
 rtl/whack_round_ctrl.sv | 156 +++++++++++++++
 tb/tb_whack_round_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/whack_round_ctrl.sv
// Round controller for a whack-a-mole pad game: shows one of seven moles per round,
// scores hits, counts misses, and narrows the visible window as the player improves.
module whack_round_ctrl #(
  parameter int GAP_CYCLES = 4,
  parameter int SHOW_INIT  = 16,
  parameter int SHOW_MIN   = 4,
  parameter int SHOW_STEP  = 2,
  parameter int ROUNDS     = 20,
  parameter int MAX_MISSES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] btn,
  input  logic [2:0] rand_seg,
  output logic       mole_on,
  output logic [2:0] mole_idx,
  output logic [7:0] score,
  output logic [3:0] misses,
  output logic [7:0] round,
  output logic       game_over,
  output logic       penalty
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_SHOW,
    S_OVER
  } state_t;

  state_t      r_state;
  logic [15:0] r_timer;
  logic [15:0] r_window;
  logic        r_start_q;
  logic [7:0]  r_btn_q;

  logic        w_start_edge;
  logic [7:0]  w_btn_edge;
  logic [7:0]  w_other_mask;
  logic        w_hit;
  logic        w_wrong;
  logic        w_last;
  logic        w_round_end;
  logic        w_miss;
  logic [3:0]  w_misses_next;
  logic [7:0]  w_round_next;
  logic [7:0]  w_score_next;
  logic [15:0] w_window_next;
  logic        w_game_end;
  logic [2:0]  w_seg;

  assign w_start_edge = start & ~r_start_q;
  assign w_btn_edge   = btn & ~r_btn_q;

  // A hit wins over a simultaneous wrong press and over a final-cycle timeout.
  assign w_other_mask  = ~(8'd1 << mole_idx);
  assign w_hit         = w_btn_edge[mole_idx];
  assign w_wrong       = |(w_btn_edge & w_other_mask);
  assign w_last        = (r_timer == 16'd1);
  assign w_round_end   = w_hit | w_wrong | w_last;
  assign w_miss        = ~w_hit & (w_wrong | w_last);

  assign w_misses_next = misses + 4'(w_miss);
  assign w_round_next  = (round == 8'hFF) ? round : round + 8'd1;
  assign w_score_next  = (score == 8'hFF) ? score : score + 8'd1;
  assign w_game_end    = (w_misses_next == 4'(MAX_MISSES)) || (w_round_next == 8'(ROUNDS));

  // Compare in 17 bits so the floor test can never wrap below zero.
  assign w_window_next = ({1'b0, r_window} >= 17'(SHOW_MIN + SHOW_STEP)) ?
                         (r_window - 16'(SHOW_STEP)) : 16'(SHOW_MIN);

  assign w_seg = (rand_seg == 3'd7) ? 3'd0 : rand_seg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_timer   <= 16'd0;
      r_window  <= 16'd0;
      r_start_q <= 1'b0;
      r_btn_q   <= 8'd0;
      mole_on   <= 1'b0;
      mole_idx  <= 3'd0;
      score     <= 8'd0;
      misses    <= 4'd0;
      round     <= 8'd0;
      game_over <= 1'b0;
      penalty   <= 1'b0;
    end else begin
      r_start_q <= start;
      r_btn_q   <= btn;
      penalty   <= 1'b0;

      if (w_start_edge) begin
        r_state   <= S_GAP;
        r_timer   <= 16'(GAP_CYCLES);
        r_window  <= 16'(SHOW_INIT);
        mole_on   <= 1'b0;
        score     <= 8'd0;
        misses    <= 4'd0;
        round     <= 8'd0;
        game_over <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            mole_on   <= 1'b0;
            game_over <= 1'b0;
          end

          S_GAP: begin
            mole_on <= 1'b0;
            if (w_last) begin
              mole_idx <= w_seg;
              r_timer  <= r_window;
              r_state  <= S_SHOW;
              mole_on  <= 1'b1;
            end else begin
              r_timer <= r_timer - 16'd1;
            end
          end

          S_SHOW: begin
            if (w_round_end) begin
              round   <= w_round_next;
              mole_on <= 1'b0;
              if (w_hit) begin
                score    <= w_score_next;
                r_window <= w_window_next;
              end else begin
                misses  <= w_misses_next;
                penalty <= 1'b1;
              end
              if (w_game_end) begin
                r_state   <= S_OVER;
                game_over <= 1'b1;
              end else begin
                r_state <= S_GAP;
                r_timer <= 16'(GAP_CYCLES);
              end
            end else begin
              r_timer <= r_timer - 16'd1;
            end
          end

          S_OVER: begin
            mole_on   <= 1'b0;
            game_over <= 1'b1;
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_whack_round_ctrl.sv
// Directed bench for whack_round_ctrl: walks several games through start, timeout,
// hits, window narrowing, round limit, held buttons and asynchronous reset.
module tb_whack_round_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] btn;
  logic [2:0] randSeg;
  logic       moleOn;
  logic [2:0] moleIdx;
  logic [7:0] score;
  logic [3:0] misses;
  logic [7:0] round;
  logic       gameOver;
  logic       penalty;

  int checks = 0;
  int errors = 0;
  int n;

  whack_round_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .btn      (btn),
    .rand_seg (randSeg),
    .mole_on  (moleOn),
    .mole_idx (moleIdx),
    .score    (score),
    .misses   (misses),
    .round    (round),
    .game_over(gameOver),
    .penalty  (penalty)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] b, input logic [2:0] seg);
    start   = s;
    btn     = b;
    randSeg = seg;
    @(negedge clk);
  endtask

  task automatic waitMole(output int cnt);
    cnt = 0;
    while (moleOn !== 1'b1 && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic countShow(output int cnt);
    cnt = 0;
    while (moleOn === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic hitAt(input int k, input logic [7:0] pressMask, input logic [7:0] holdMask, input string tag);
    repeat (k - 1) @(negedge clk);
    checkOutput({tag, " moleOn before press"}, 32'(moleOn), 1);
    btn = pressMask | holdMask;
    @(negedge clk);
    btn = holdMask;
  endtask

  initial begin
    int wins[6] = '{12, 10, 8, 6, 4, 4};
    logic [2:0] seg;

    rst_n = 1'b0; start = 1'b0; btn = 8'd0; randSeg = 3'd0;
    #3;
    checkOutput("reset outputs", 32'({moleOn, moleIdx, score, misses, round, gameOver, penalty}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 3'd0);
    applyStimulus(1'b0, 8'h10, 3'd0);
    checkOutput("idle no mole", 32'({moleOn, gameOver}), 0);

    // Game A: start latency, timeout, single hit, narrowed window, game over on misses
    applyStimulus(1'b1, 8'h00, 3'd7);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("gap moleOn low", 32'(moleOn), 0);
    @(negedge clk);
    checkOutput("start moleOn rises", 32'(moleOn), 1);
    checkOutput("seg7 maps to 0", 32'(moleIdx), 0);

    countShow(n);
    checkOutput("show0 length", n, 16);
    checkOutput("timeout penalty", 32'(penalty), 1);
    checkOutput("timeout misses", 32'(misses), 1);
    checkOutput("timeout round", 32'(round), 1);
    randSeg = 3'd3;
    @(negedge clk);
    checkOutput("penalty one cycle", 32'(penalty), 0);
    waitMole(n);
    checkOutput("gap after miss", n, 3);
    checkOutput("idx 3", 32'(moleIdx), 3);

    hitAt(2, 8'h08, 8'h00, "hit2");
    checkOutput("hit score", 32'(score), 1);
    checkOutput("hit round", 32'(round), 2);
    checkOutput("hit misses", 32'(misses), 1);
    checkOutput("hit no penalty", 32'(penalty), 0);
    checkOutput("hit mole off", 32'(moleOn), 0);

    randSeg = 3'd5;
    waitMole(n);
    checkOutput("gap length", n, 4);
    checkOutput("idx 5", 32'(moleIdx), 5);
    countShow(n);
    checkOutput("window 14 length", n, 14);
    checkOutput("miss2 misses", 32'(misses), 2);
    checkOutput("miss2 penalty", 32'(penalty), 1);

    randSeg = 3'd2;
    waitMole(n);
    countShow(n);
    checkOutput("window 14 again", n, 14);
    checkOutput("over gameOver", 32'(gameOver), 1);
    checkOutput("over misses", 32'(misses), 3);
    checkOutput("over score held", 32'(score), 1);
    checkOutput("over round", 32'(round), 4);

    applyStimulus(1'b0, 8'hFF, 3'd6);
    btn = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("over hold", 32'({moleOn, gameOver, penalty, moleIdx, score, misses, round}),
                32'({1'b0, 1'b1, 1'b0, 3'd2, 8'd1, 4'd3, 8'd4}));

    applyStimulus(1'b1, 8'h00, 3'd4);
    start = 1'b0;
    checkOutput("restart clears", 32'({moleOn, gameOver, score, misses, round}), 0);

    // Game B: simultaneous press, held button, final-cycle hits, window floor, round limit
    randSeg = 3'd3;
    waitMole(n);
    checkOutput("restart gap", n, 4);
    checkOutput("idx 3 again", 32'(moleIdx), 3);
    hitAt(1, 8'h28, 8'h20, "dual");
    checkOutput("dual score", 32'(score), 1);
    checkOutput("dual misses", 32'(misses), 0);

    randSeg = 3'd1;
    waitMole(n);
    checkOutput("held idx 1", 32'(moleIdx), 1);
    hitAt(14, 8'h02, 8'h20, "final14");
    checkOutput("held no miss", 32'(misses), 0);
    checkOutput("final14 score", 32'(score), 2);
    btn = 8'h00;

    for (int i = 0; i < 6; i++) begin
      seg = 3'(i % 7);
      randSeg = seg;
      waitMole(n);
      hitAt(wins[i], 8'd1 << seg, 8'h00, $sformatf("final%0d", wins[i]));
      checkOutput($sformatf("floor seq misses %0d", i), 32'(misses), 0);
    end
    checkOutput("floor seq score", 32'(score), 8);

    for (int i = 0; i < 12; i++) begin
      seg = 3'((i + 2) % 7);
      randSeg = seg;
      waitMole(n);
      hitAt(1, 8'd1 << seg, 8'h00, "fast");
    end
    checkOutput("limit round", 32'(round), 20);
    checkOutput("limit score", 32'(score), 20);
    checkOutput("limit gameOver", 32'({gameOver, moleOn}), 32'(2'b10));
    checkOutput("limit misses", 32'(misses), 0);

    // Game C: seven hits then a timeout shows the window sits at the floor
    applyStimulus(1'b1, 8'h00, 3'd0);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      seg = 3'((i + 4) % 7);
      randSeg = seg;
      waitMole(n);
      hitAt(1, 8'd1 << seg, 8'h00, "warm");
    end
    waitMole(n);
    countShow(n);
    checkOutput("floor window length", n, 4);
    checkOutput("floor miss", 32'({misses, score}), 32'({4'd1, 8'd7}));

    // Game D: asynchronous reset mid-SHOW, then start held high across release
    applyStimulus(1'b1, 8'h00, 3'd0);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seg = 3'(i % 7);
      randSeg = seg;
      waitMole(n);
      hitAt(1, 8'd1 << seg, 8'h00, "pre reset");
    end
    waitMole(n);
    @(negedge clk);
    checkOutput("pre reset score", 32'({moleOn, score}), 32'({1'b1, 8'd5}));
    start = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset outputs", 32'({moleOn, moleIdx, score, misses, round, gameOver, penalty}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("start at release", 32'({moleOn, gameOver, score}), 0);
    repeat (3) @(negedge clk);
    checkOutput("release gap low", 32'(moleOn), 0);
    @(negedge clk);
    checkOutput("release mole on", 32'(moleOn), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
